// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg -- shared types and constants for the ROM loader.
//   state_t      : loader FSM states
//   ERR_*        : err_code values reported on the err_code port
//   HDR_*_DEF    : default frame header bytes (PMEM / EMEM target)
package rom_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT,
    COLLECT,
    WRITE,
    VADDR,
    VSAMP,
    DONE
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_HDR    = 2'd1;
  localparam logic [1:0] ERR_CNT    = 2'd2;
  localparam logic [1:0] ERR_VERIFY = 2'd3;

  localparam logic [7:0] HDR_PMEM_DEF = 8'hA0;
  localparam logic [7:0] HDR_EMEM_DEF = 8'hA1;

endpackage

// File: rtl/rom_loader_asm.sv
// rom_loader_asm -- 4-byte little-endian word assembler.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : restart at byte lane 0 (start of a new frame body)
//   i_load         : store i_byte into the current lane and advance
//   i_byte         : incoming data byte
//   o_word         : assembled word (first byte lands in bits [7:0])
//   o_last         : the current lane is the 4th, so the next load completes the word
module rom_loader_asm (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_last
);

  logic [31:0] r_word;
  logic [1:0]  r_lane;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_clr) begin
      r_lane <= '0;
    end else if (i_load) begin
      r_word[{r_lane, 3'b000} +: 8] <= i_byte;
      // 2-bit lane counter wraps to 0 after the 4th byte, ready for the next word
      r_lane <= r_lane + 2'd1;
    end
  end

  assign o_word = r_word;
  assign o_last = (r_lane == 2'd3);

endmodule

// File: rtl/rom_loader.sv
// rom_loader -- byte-stream ROM loader: receives a framed image
// (header, count N, 4*N little-endian data bytes), writes it to PMEM or
// EMEM through the ROM load port, optionally verifies it by readback
// (XOR checksum of written vs. read words), then releases the CPU.
// Optional feature macro: ROM_LOADER_VERIFY_EN (readback verify pass).
// Ports:
//   sys_clk, sys_rst         : clock, asynchronous active-low reset
//   in_valid/in_data/in_ready: host byte stream handshake
//   rom_we/rom_select/rom_addr/rom_wd/rom_rd : ROM load port
//   cpu_hold                 : holds the core in reset while loading
//   busy/done/err/err_code   : frame status (done/err sticky)
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         DEPTH    = 64,
  parameter int         ADDR_W   = 6,
  parameter logic [7:0] HDR_PMEM = HDR_PMEM_DEF,
  parameter logic [7:0] HDR_EMEM = HDR_EMEM_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic              rom_select,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wd,
  input  logic [31:0]       rom_rd,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_last_idx;
  logic              r_we;
  logic              r_sel;
  logic              r_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_xfer;
  logic              w_in_ready;
  logic              w_asm_clr;
  logic              w_asm_load;
  logic              w_last;
  logic [31:0]       w_word;

`ifdef ROM_LOADER_VERIFY_EN
  logic [31:0]       r_sum_w;
  logic [31:0]       r_sum_r;
  logic [31:0]       w_sum_r_next;
  assign w_sum_r_next = r_sum_r ^ rom_rd;
`else
  logic              w_unused_rd;
  assign w_unused_rd = ^rom_rd;
`endif

  // Gated with reset so the host sees no acceptance while reset is held.
  assign w_in_ready = sys_rst &&
                      ((r_state == IDLE) || (r_state == CNT) || (r_state == COLLECT));
  assign w_xfer     = in_valid && w_in_ready;
  assign w_asm_clr  = (r_state == CNT) && w_xfer;
  assign w_asm_load = (r_state == COLLECT) && w_xfer;

  rom_loader_asm u_asm (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst),
    .i_clr   (w_asm_clr),
    .i_load  (w_asm_load),
    .i_byte  (in_data),
    .o_word  (w_word),
    .o_last  (w_last)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_we       <= 1'b0;
      r_sel      <= 1'b0;
      r_hold     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
`ifdef ROM_LOADER_VERIFY_EN
      r_sum_w    <= '0;
      r_sum_r    <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if ((in_data == HDR_PMEM) || (in_data == HDR_EMEM)) begin
              r_sel      <= (in_data == HDR_EMEM);
              r_done     <= 1'b0;
              r_err      <= 1'b0;
              r_err_code <= ERR_NONE;
              r_hold     <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= CNT;
            end else begin
              r_err      <= 1'b1;
              r_err_code <= ERR_HDR;
            end
          end
        end
        CNT: begin
          if (w_xfer) begin
            if ((in_data == 8'd0) || (32'(in_data) > DEPTH)) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_CNT;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_last_idx <= ADDR_W'(in_data - 8'd1);
              r_idx      <= '0;
`ifdef ROM_LOADER_VERIFY_EN
              r_sum_w    <= '0;
`endif
              r_state    <= COLLECT;
            end
          end
        end
        COLLECT: begin
          // The assembler stores the 4th byte on this same edge, so rom_wd
          // holds the complete word for the whole WRITE cycle.
          if (w_xfer && w_last) begin
            r_we    <= 1'b1;
            r_state <= WRITE;
          end
        end
        WRITE: begin
`ifdef ROM_LOADER_VERIFY_EN
          r_sum_w <= r_sum_w ^ w_word;
`endif
          if (r_idx == r_last_idx) begin
`ifdef ROM_LOADER_VERIFY_EN
            r_idx   <= '0;
            r_sum_r <= '0;
            r_state <= VADDR;
`else
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_hold  <= 1'b0;
            r_state <= DONE;
`endif
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= COLLECT;
          end
        end
`ifdef ROM_LOADER_VERIFY_EN
        VADDR: begin
          // One cycle for the address to settle before sampling rom_rd.
          r_state <= VSAMP;
        end
        VSAMP: begin
          r_sum_r <= w_sum_r_next;
          if (r_idx == r_last_idx) begin
            if (w_sum_r_next == r_sum_w) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_hold  <= 1'b0;
              r_state <= DONE;
            end else begin
              r_err      <= 1'b1;
              r_err_code <= ERR_VERIFY;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
            end
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= VADDR;
          end
        end
`endif
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign rom_we     = r_we;
  assign rom_select = r_sel;
  assign rom_addr   = r_idx;
  assign rom_wd     = w_word;
  assign cpu_hold   = r_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader -- scoreboard bench for rom_loader. Expected ROM writes and
// frame outcomes are queued as stimulus is issued; a monitor pops and
// compares on every rom_we pulse and on every rising done/err.
// Honours ROM_LOADER_VERIFY_EN for the readback-mismatch expectation.
module tb_rom_loader;
  import rom_loader_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        rom_we;
  logic        rom_select;
  logic [5:0]  rom_addr;
  logic [31:0] rom_wd;
  logic [31:0] rom_rd;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  always #5 sys_clk = ~sys_clk;

  rom_loader #(.DEPTH(64), .ADDR_W(6), .HDR_PMEM(8'hA0), .HDR_EMEM(8'hA1)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rom_we     (rom_we),
    .rom_select (rom_select),
    .rom_addr   (rom_addr),
    .rom_wd     (rom_wd),
    .rom_rd     (rom_rd),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  // ROM model: two banks, optional single-bit corruption at address 3.
  logic [31:0] pmem [64];
  logic [31:0] emem [64];
  logic        corrupt = 1'b0;

  always @(posedge sys_clk) begin
    if (rom_we) begin
      if (rom_select) emem[rom_addr] <= rom_wd;
      else            pmem[rom_addr] <= rom_wd;
    end
  end

  assign rom_rd = (rom_select ? emem[rom_addr] : pmem[rom_addr]) ^
                  ((corrupt && (rom_addr == 6'd3)) ? 32'd1 : 32'd0);

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wd;
    logic        sel;
  } wr_t;

  typedef struct {
    logic       done;
    logic       err;
    logic       hold;
    logic       sel;
    logic [1:0] code;
  } out_t;

  wr_t         exp_wr[$];
  out_t        exp_out[$];
  logic [31:0] wq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic monitor_loop();
    logic p_done;
    logic p_err;
    wr_t  w;
    out_t o;
    p_done = 1'b0;
    p_err  = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
        p_done = 1'b0;
        p_err  = 1'b0;
      end else begin
        if (rom_we) begin
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data %h, expected no write", rom_addr, rom_wd);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(rom_addr), 32'(w.addr));
            chk("wr_data", rom_wd, w.wd);
            chk("wr_sel", 32'(rom_select), 32'(w.sel));
            chk("wr_in_ready_low", 32'(in_ready), 32'd0);
          end
        end
        if ((done && !p_done) || (err && !p_err)) begin
          if (exp_out.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_status: done %0d err %0d code %0d, expected no frame end", done, err, err_code);
          end else begin
            o = exp_out.pop_front();
            $display("frame end: done %0d err %0d code %0d hold %0d sel %0d", done, err, err_code, cpu_hold, rom_select);
            chk("st_done", 32'(done), 32'(o.done));
            chk("st_err", 32'(err), 32'(o.err));
            chk("st_code", 32'(err_code), 32'(o.code));
            chk("st_hold", 32'(cpu_hold), 32'(o.hold));
            chk("st_sel", 32'(rom_select), 32'(o.sel));
            chk("st_busy", 32'(busy), 32'd0);
          end
        end
        p_done = done;
        p_err  = err;
      end
    end
  endtask

  // Called at a negedge; leaves in_valid high so consecutive calls stream.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0, expected 1 for byte %h", b);
    end
    @(negedge sys_clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic load_frame(input logic [7:0] hdr);
    send_byte(hdr);
    send_byte(8'(wq.size()));
    for (int i = 0; i < wq.size(); i++) begin
      exp_wr.push_back('{addr: 6'(i), wd: wq[i], sel: (hdr == 8'hA1)});
      send_word(wq[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_wr.size() != 0 || exp_out.size() != 0) && t < 1000) begin
      @(negedge sys_clk);
      t++;
    end
    checks++;
    if (exp_wr.size() != 0 || exp_out.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d writes and %0d outcomes pending, expected 0",
               name, exp_wr.size(), exp_out.size());
      exp_wr.delete();
      exp_out.delete();
    end
  endtask

  task automatic do_reset();
    sys_rst  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset state (reset held from time 0)
    @(negedge sys_clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(rom_we), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_wd", rom_wd, 32'd0);
    chk("rst_sel", 32'(rom_select), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // PMEM load of two words
    $display("txn: PMEM load N=2");
    wq = {};
    wq.push_back(32'h12345678);
    wq.push_back(32'hDEADBEEF);
    exp_out.push_back('{done: 1'b1, err: 1'b0, hold: 1'b0, sel: 1'b0, code: ERR_NONE});
    load_frame(8'hA0);
    wait_drain("pmem");

    // Bad header after reset, then a valid EMEM frame
    do_reset();
    $display("txn: bad header 55");
    exp_out.push_back('{done: 1'b0, err: 1'b1, hold: 1'b1, sel: 1'b0, code: ERR_HDR});
    send_byte(8'h55);
    in_valid = 1'b0;
    wait_drain("badhdr");
    $display("txn: EMEM load N=1");
    wq = {};
    wq.push_back(32'hCAFEF00D);
    exp_out.push_back('{done: 1'b1, err: 1'b0, hold: 1'b0, sel: 1'b1, code: ERR_NONE});
    load_frame(8'hA1);
    wait_drain("emem");

    // Count 0 and count 65
    $display("txn: count 0");
    exp_out.push_back('{done: 1'b0, err: 1'b1, hold: 1'b1, sel: 1'b0, code: ERR_CNT});
    send_byte(8'hA0);
    send_byte(8'h00);
    in_valid = 1'b0;
    chk("cnt0_in_ready", 32'(in_ready), 32'd1);
    wait_drain("cnt0");
    $display("txn: count 65");
    exp_out.push_back('{done: 1'b0, err: 1'b1, hold: 1'b1, sel: 1'b0, code: ERR_CNT});
    send_byte(8'hA0);
    send_byte(8'd65);
    in_valid = 1'b0;
    chk("cnt65_in_ready", 32'(in_ready), 32'd1);
    wait_drain("cnt65");

    // Readback corrupted at address 3
    $display("txn: verify mismatch N=4");
    corrupt = 1'b1;
    wq = {};
    wq.push_back(32'h00000001);
    wq.push_back(32'h10203040);
    wq.push_back(32'hA5A55A5A);
    wq.push_back(32'h0F0F0F0E);
`ifdef ROM_LOADER_VERIFY_EN
    exp_out.push_back('{done: 1'b0, err: 1'b1, hold: 1'b1, sel: 1'b0, code: ERR_VERIFY});
`else
    exp_out.push_back('{done: 1'b1, err: 1'b0, hold: 1'b0, sel: 1'b0, code: ERR_NONE});
`endif
    load_frame(8'hA0);
    wait_drain("verify");
    corrupt = 1'b0;

    // Full-depth load with in_valid held high throughout
    $display("txn: full load N=64");
    wq = {};
    for (int i = 0; i < 64; i++)
      wq.push_back({8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)} ^ 32'h5A000000);
    exp_out.push_back('{done: 1'b1, err: 1'b0, hold: 1'b0, sel: 1'b0, code: ERR_NONE});
    load_frame(8'hA0);
    wait_drain("full");

    // Reset mid-frame after 6 data bytes
    $display("txn: reset mid-frame");
    exp_wr.push_back('{addr: 6'd0, wd: 32'h11223344, sel: 1'b0});
    send_byte(8'hA0);
    send_byte(8'h04);
    send_word(32'h11223344);
    send_byte(8'h88);
    send_byte(8'h77);
    #2;
    sys_rst  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_we", 32'(rom_we), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hold", 32'(cpu_hold), 32'd1);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_wd", rom_wd, 32'd0);
    chk("arst_addr", 32'(rom_addr), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    wait_drain("midrst");
    $display("txn: clean EMEM load after reset");
    wq = {};
    wq.push_back(32'h0BADCAFE);
    exp_out.push_back('{done: 1'b1, err: 1'b0, hold: 1'b0, sel: 1'b1, code: ERR_NONE});
    load_frame(8'hA1);
    wait_drain("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Byte-stream initiator that drives the system's ROM load port (rom_we, rom_select, rom_addr, rom_wd, rom_rd).
- Loads a framed program image into PMEM or EMEM, optionally verifies it by readback, then releases the CPU.
- Sits between a host byte source (UART RX, JTAG shim or testbench) and the system top.
- Replaces testbench-driven ROM loading on silicon/FPGA builds.

Parameters:
- DEPTH, 64: ROM depth in words; legal word count is 1..DEPTH.
- ADDR_W, 6: ROM address width; must equal clog2(DEPTH).
- HDR_PMEM, 8'hA0: header byte that selects PMEM (rom_select=0).
- HDR_EMEM, 8'hA1: header byte that selects EMEM (rom_select=1).

Ports:
- sys_clk  in  1  system clock; all state on the rising edge.
- sys_rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts byte; a transfer occurs when in_valid & in_ready at a clock edge.
- rom_we  out  1  ROM write enable.
- rom_select  out  1  0=PMEM, 1=EMEM.
- rom_addr  out  ADDR_W  ROM word address.
- rom_wd  out  32  ROM write data.
- rom_rd  in  32  ROM readback data (combinational from rom_addr/rom_select).
- cpu_hold  out  1  drives system reset; holds the core while loading.
- busy  out  1  frame in progress.
- done  out  1  last frame completed OK; sticky.
- err  out  1  last frame failed; sticky.
- err_code  out  2  0 none, 1 bad header, 2 bad count, 3 verify mismatch.

Behaviour:
- Reset (async, sys_rst=0):
  - State=IDLE; rom_we=0, rom_addr=0, rom_wd=0, rom_select=0.
  - in_ready=0 while in reset, then 1 in IDLE.
  - cpu_hold=1, busy=0, done=0, err=0, err_code=0, internal checksums=0.
- Reset asserted mid-frame aborts immediately: rom_we drops asynchronously and no partial state survives.
- Frame format: header byte, count byte N, then 4*N data bytes per word, little-endian (first byte → rom_wd[7:0]).
- IDLE (in_ready=1). On a byte transfer:
  - byte==HDR_PMEM or HDR_EMEM: latch rom_select; clear done/err/err_code; cpu_hold=1; busy=1; go to CNT.
  - Any other byte: err=1, err_code=1, cpu_hold stays 1, stay in IDLE.
- CNT (in_ready=1): latch N.
  - N==0 or N>DEPTH: err=1, err_code=2, busy=0, go to IDLE.
  - Otherwise: word index=0, byte index=0, sum_w=0, go to COLLECT.
- COLLECT (in_ready=1): shift each accepted byte into rom_wd at byte-index lane. On the 4th byte, go to WRITE.
- WRITE (in_ready=0, exactly one cycle):
  - rom_we=1, rom_addr=index, rom_wd=assembled word; sum_w ^= word.
  - Next cycle rom_we=0.
  - If index==N-1: go to VERIFY (or DONE if verify compiled out).
  - Else: index+1, back to COLLECT.
- Latency: WRITE is the cycle after the 4th byte transfer; the earliest next byte is accepted the cycle after WRITE.
- VERIFY (in_ready=0, 2 cycles per word):
  - VADDR drives rom_addr=index.
  - VSAMP holds rom_addr and samples sum_r ^= rom_rd.
  - After index N-1, compare sum_r with sum_w. Equal → DONE; unequal → err=1, err_code=3, busy=0, IDLE with cpu_hold=1.
- DONE: done=1, busy=0, cpu_hold=0 on the same edge; return to IDLE next cycle.
- Index never exceeds N-1 ≤ DEPTH-1; no address wrap is possible.
- in_valid while in_ready=0 is held off; the byte is not lost or duplicated.
- A header byte received mid-frame is treated as data; a frame is only terminated by its count.
- A new frame after DONE re-asserts cpu_hold on header acceptance.

Optional Feature:
- ROM_LOADER_VERIFY_EN defined: VERIFY pass as above; err_code=3 is reachable.
- Undefined:
  - VERIFY states, sum_w and sum_r are removed.
  - WRITE of the last word goes directly to DONE.
  - err_code=3 is never produced.

Decomposition:
- Shared package rom_loader_pkg:
  - state enum: IDLE, CNT, COLLECT, WRITE, VADDR, VSAMP, DONE.
  - err_code constants: ERR_NONE, ERR_HDR, ERR_CNT, ERR_VERIFY.
  - default header byte constants.
- One natural sub-module: rom_loader_asm, the 4-byte little-endian word assembler with byte counter and full flag; the FSM stays in rom_loader.

Test Plan:
- PMEM load: A0, 02, 78 56 34 12, EF BE AD DE → rom_we pulses at addr 0 (wd=12345678) and addr 1 (wd=DEADBEEF); rom_select=0; verify passes; done=1, cpu_hold=0, err_code=0.
- Bad header 0x55 after reset → err=1, err_code=1, cpu_hold=1, no rom_we; then a valid A1 frame with N=1 → done=1, rom_select=1.
- Count 0 and count 65 each → err_code=2, no rom_we, in_ready=1 next cycle.
- Verify mismatch: model the ROM to corrupt addr 3 (bit 0 flipped) with N=4 → err_code=3, done=0, cpu_hold=1.
- Backpressure and N=64 full load, in_valid held high continuously → 64 writes at addr 0..63, in_ready=0 on each WRITE cycle, no byte lost or duplicated; done=1.
- Reset mid-frame after 6 data bytes → all outputs reach reset values asynchronously; the next clean frame loads correctly.
